// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine datapath.
//   - Coin codes (same coding as the controller coin bus) and their values.
//     Each code is numerically equal to the coin's value, so a code can be
//     used directly as the value to subtract.
//   - State encodings for the change dispenser FSM.
//   - Default width for amounts.
package vend_pkg;

  localparam int AMT_W_DEF = 7;

  localparam logic [4:0] COIN5  = 5'b00101;
  localparam logic [4:0] COIN10 = 5'b01010;
  localparam logic [4:0] COIN20 = 5'b10100;

  localparam int VAL5  = 5;
  localparam int VAL10 = 10;
  localparam int VAL20 = 20;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SELECT   = 3'd1;
  localparam logic [2:0] ST_DISPENSE = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;
  localparam logic [2:0] ST_ERR      = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    SELECT   = ST_SELECT,
    DISPENSE = ST_DISPENSE,
    GAP      = ST_GAP,
    DONE     = ST_DONE,
    ERR      = ST_ERR
  } state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the change dispenser and its neighbours.
//   chg_valid/chg_amt/chg_ready : change request from the controller
//   coin_valid/coin_val/coin_ready : one-coin-at-a-time ejector handshake
// Modports:
//   slave  - the dispenser side (consumes requests, presents coins)
//   master - the environment side (issues requests, accepts coins)
interface change_dispenser_if #(
  parameter int AMT_W = vend_pkg::AMT_W_DEF
) ();
  logic             chg_valid;
  logic [AMT_W-1:0] chg_amt;
  logic             chg_ready;
  logic             coin_valid;
  logic [4:0]       coin_val;
  logic             coin_ready;

  modport slave (
    input  chg_valid, chg_amt, coin_ready,
    output chg_ready, coin_valid, coin_val
  );

  modport master (
    output chg_valid, chg_amt, coin_ready,
    input  chg_ready, coin_valid, coin_val
  );
endinterface

// File: rtl/change_dispenser_coin_inventory.sv
// coin_inventory: three per-denomination stock counters for the change
// dispenser. Only present when CHG_INVENTORY_EN is defined.
// Ports:
//   clk, resetn            - clock, synchronous active-low reset
//   reload                 - restock every denomination to INV_INIT
//   dec_5/dec_10/dec_20    - one coin of that denomination was paid out
//   inv_5/inv_10/inv_20    - current stock
//   avail_5/10/20          - stock of that denomination is non-zero
`ifdef CHG_INVENTORY_EN
module coin_inventory #(
  parameter int INV_W    = 6,
  parameter int INV_INIT = 20
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             reload,
  input  logic             dec_5,
  input  logic             dec_10,
  input  logic             dec_20,
  output logic [INV_W-1:0] inv_5,
  output logic [INV_W-1:0] inv_10,
  output logic [INV_W-1:0] inv_20,
  output logic             avail_5,
  output logic             avail_10,
  output logic             avail_20
);
  localparam logic [INV_W-1:0] INIT_V = INV_W'(INV_INIT);

  logic [INV_W-1:0] inv5_q, inv5_d;
  logic [INV_W-1:0] inv10_q, inv10_d;
  logic [INV_W-1:0] inv20_q, inv20_d;

  // Reload has priority over a coincident decrement. A decrement is only
  // ever requested for a denomination flagged available, so no underflow.
  always_comb begin
    inv5_d  = inv5_q;
    inv10_d = inv10_q;
    inv20_d = inv20_q;
    if (reload) begin
      inv5_d  = INIT_V;
      inv10_d = INIT_V;
      inv20_d = INIT_V;
    end else begin
      if (dec_5)  inv5_d  = inv5_q  - 1'b1;
      if (dec_10) inv10_d = inv10_q - 1'b1;
      if (dec_20) inv20_d = inv20_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      inv5_q  <= INIT_V;
      inv10_q <= INIT_V;
      inv20_q <= INIT_V;
    end else begin
      inv5_q  <= inv5_d;
      inv10_q <= inv10_d;
      inv20_q <= inv20_d;
    end
  end

  assign inv_5    = inv5_q;
  assign inv_10   = inv10_q;
  assign inv_20   = inv20_q;
  assign avail_5  = (inv5_q  != '0);
  assign avail_10 = (inv10_q != '0);
  assign avail_20 = (inv20_q != '0);
endmodule
`endif

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a returned-change amount one coin at a time,
// greedy 20/10/5, with a valid/ready handshake per coin and a settle gap
// of GAP_CYCLES idle cycles after each coin.
// Ports:
//   clk, resetn   - clock, synchronous active-low reset
//   bus (slave)   - change request in, coin handshake out
//   busy          - not in IDLE
//   done          - one-cycle pulse, request fully paid
//   short_err     - one-cycle pulse, request ended with unpaid residue
//   remaining     - amount still owed (residue held after short_err)
//   reload, inv_5/inv_10/inv_20 - only with CHG_INVENTORY_EN
// Build option: define CHG_INVENTORY_EN for finite per-denomination stock;
// otherwise supply is unlimited.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W      = AMT_W_DEF,
  parameter int GAP_CYCLES = 2
`ifdef CHG_INVENTORY_EN
  ,
  parameter int INV_W      = 6,
  parameter int INV_INIT   = 20
`endif
) (
  input  logic             clk,
  input  logic             resetn,
  change_dispenser_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic             short_err,
  output logic [AMT_W-1:0] remaining
`ifdef CHG_INVENTORY_EN
  ,
  input  logic             reload,
  output logic [INV_W-1:0] inv_5,
  output logic [INV_W-1:0] inv_10,
  output logic [INV_W-1:0] inv_20
`endif
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [AMT_W-1:0] AMT5  = AMT_W'(VAL5);
  localparam logic [AMT_W-1:0] AMT10 = AMT_W'(VAL10);
  localparam logic [AMT_W-1:0] AMT20 = AMT_W'(VAL20);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [4:0]       coin_val_q, coin_val_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             avail_5, avail_10, avail_20;

`ifdef CHG_INVENTORY_EN
  logic take;
  assign take = (state_q == DISPENSE) && bus.coin_ready;

  coin_inventory #(
    .INV_W   (INV_W),
    .INV_INIT(INV_INIT)
  ) u_inv (
    .clk     (clk),
    .resetn  (resetn),
    .reload  (reload),
    .dec_5   (take && (coin_val_q == COIN5)),
    .dec_10  (take && (coin_val_q == COIN10)),
    .dec_20  (take && (coin_val_q == COIN20)),
    .inv_5   (inv_5),
    .inv_10  (inv_10),
    .inv_20  (inv_20),
    .avail_5 (avail_5),
    .avail_10(avail_10),
    .avail_20(avail_20)
  );
`else
  assign avail_5  = 1'b1;
  assign avail_10 = 1'b1;
  assign avail_20 = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_val_d  = coin_val_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.chg_valid) begin
          remaining_d = bus.chg_amt;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if (remaining_q >= AMT20 && avail_20) begin
          coin_val_d = COIN20;
          state_d    = DISPENSE;
        end else if (remaining_q >= AMT10 && avail_10) begin
          coin_val_d = COIN10;
          state_d    = DISPENSE;
        end else if (remaining_q >= AMT5 && avail_5) begin
          coin_val_d = COIN5;
          state_d    = DISPENSE;
        end else begin
          state_d = ERR;
        end
      end
      DISPENSE: begin
        if (bus.coin_ready) begin
          // coin code doubles as its value; SELECT guaranteed it fits
          remaining_d = remaining_q - AMT_W'(coin_val_q);
          if (GAP_CYCLES > 0) begin
            gap_cnt_d = GAP_LOAD;
            state_d   = GAP;
          end else begin
            state_d = SELECT;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = SELECT;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      coin_val_q  <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_val_q  <= coin_val_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign bus.chg_ready  = (state_q == IDLE);
  assign bus.coin_valid = (state_q == DISPENSE);
  assign bus.coin_val   = (state_q == DISPENSE) ? coin_val_q : 5'b00000;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign short_err      = (state_q == ERR);
  assign remaining      = remaining_q;
endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  import vend_pkg::*;

  localparam int AW  = 7;
  localparam int GAP = 2;
  localparam int EV_DONE = 100;
  localparam int EV_ERR  = 200;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  change_dispenser_if #(.AMT_W(AW)) bus ();
  logic          busy, done, short_err;
  logic [AW-1:0] remaining;
`ifdef CHG_INVENTORY_EN
  logic       reload;
  logic [5:0] inv_5, inv_10, inv_20;
`endif

  change_dispenser #(
    .AMT_W     (AW),
    .GAP_CYCLES(GAP)
`ifdef CHG_INVENTORY_EN
    ,
    .INV_W     (6),
    .INV_INIT  (20)
`endif
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .short_err(short_err),
    .remaining(remaining)
`ifdef CHG_INVENTORY_EN
    ,
    .reload   (reload),
    .inv_5    (inv_5),
    .inv_10   (inv_10),
    .inv_20   (inv_20)
`endif
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input string name, input int act);
    if (exp_q.size() == 0) chk({name, "_unexpected"}, act, -1);
    else                   chk(name, act, exp_q.pop_front());
  endtask

  // Monitor: every coin handshake, done and short_err pulse is matched
  // against the next expected event.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.coin_valid && bus.coin_ready) expect_ev("coin", int'(bus.coin_val));
      if (done)      expect_ev("done", EV_DONE);
      if (short_err) expect_ev("short_err", EV_ERR);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int amt);
    int n = 0;
    while (!bus.chg_ready && n < 100) begin tick(); n++; end
    chk("req_ready", int'(bus.chg_ready), 1);
    bus.chg_valid = 1'b1;
    bus.chg_amt   = AW'(amt);
    tick();
    bus.chg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin tick(); n++; end
    chk("idle_reached", int'(busy), 0);
  endtask

  task automatic wait_coin();
    int n = 0;
    while (!bus.coin_valid && n < 50) begin tick(); n++; end
    chk("coin_presented", int'(bus.coin_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn         = 1'b0;
    bus.chg_valid  = 1'b0;
    bus.chg_amt    = '0;
    bus.coin_ready = 1'b1;
`ifdef CHG_INVENTORY_EN
    reload = 1'b0;
`endif
    repeat (3) tick();

    // Reset state
    chk("rst_chg_ready", int'(bus.chg_ready), 1);
    chk("rst_coin_valid", int'(bus.coin_valid), 0);
    chk("rst_coin_val", int'(bus.coin_val), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_short_err", int'(short_err), 0);
    chk("rst_remaining", int'(remaining), 0);
`ifdef CHG_INVENTORY_EN
    chk("rst_inv_20", int'(inv_20), 20);
`endif
    resetn = 1'b1;
    tick();

    // 35 -> 20, 10, 5, done
    exp_q.push_back(20); exp_q.push_back(10); exp_q.push_back(5); exp_q.push_back(EV_DONE);
    request(35);
    wait_idle();
    chk("t35_remaining", int'(remaining), 0);
    chk("t35_drained", exp_q.size(), 0);
`ifdef CHG_INVENTORY_EN
    chk("t35_inv_20", int'(inv_20), 19);
    chk("t35_inv_10", int'(inv_10), 19);
    chk("t35_inv_5", int'(inv_5), 19);
`endif

    // Zero request: done sampled at T+2, chg_ready back at T+3
    exp_q.push_back(EV_DONE);
    request(0);
    @(negedge clk);
    chk("t0_done_t1", int'(done), 0);
    chk("t0_no_coin", int'(bus.coin_valid), 0);
    @(negedge clk);
    chk("t0_done_t2", int'(done), 1);
    @(negedge clk);
    chk("t0_ready_t3", int'(bus.chg_ready), 1);
    chk("t0_done_off", int'(done), 0);
    tick();
    chk("t0_drained", exp_q.size(), 0);

    // 37 -> 20, 10, 5, short_err with residue 2
    exp_q.push_back(20); exp_q.push_back(10); exp_q.push_back(5); exp_q.push_back(EV_ERR);
    request(37);
    wait_idle();
    chk("t37_remaining", int'(remaining), 2);
    chk("t37_drained", exp_q.size(), 0);

    // 3 -> immediate short_err, residue 3
    exp_q.push_back(EV_ERR);
    request(3);
    wait_idle();
    chk("t3_remaining", int'(remaining), 3);
    chk("t3_drained", exp_q.size(), 0);

`ifdef CHG_INVENTORY_EN
    // Exhaust the 20s, then 40 must be paid with four 10s
    reload = 1'b1; tick(); reload = 1'b0;
    chk("reload1_inv_20", int'(inv_20), 20);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(20); exp_q.push_back(EV_DONE);
      request(20);
      wait_idle();
    end
    chk("exhaust_inv_20", int'(inv_20), 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(10);
    exp_q.push_back(EV_DONE);
    request(40);
    wait_idle();
    chk("t40_inv_10", int'(inv_10), 16);
    chk("t40_drained", exp_q.size(), 0);
    reload = 1'b1; tick(); reload = 1'b0;
    chk("reload2_inv_20", int'(inv_20), 20);
    chk("reload2_inv_10", int'(inv_10), 20);
`else
    exp_q.push_back(20); exp_q.push_back(20); exp_q.push_back(EV_DONE);
    request(40);
    wait_idle();
    chk("t40_drained", exp_q.size(), 0);
`endif

    // 20 with coin_ready held low: coin stable, chg_valid ignored
    bus.coin_ready = 1'b0;
    exp_q.push_back(20); exp_q.push_back(EV_DONE);
    request(20);
    wait_coin();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", int'(bus.coin_valid), 1);
      chk("hold_val", int'(bus.coin_val), 20);
      if (i == 1) begin bus.chg_valid = 1'b1; bus.chg_amt = AW'(5); end
      if (i == 3) bus.chg_valid = 1'b0;
      tick();
    end
    bus.coin_ready = 1'b1;
    tick();
    chk("hold_released", int'(bus.coin_valid), 0);
    wait_idle();
    repeat (8) tick();
    chk("hold_remaining", int'(remaining), 0);
    chk("hold_drained", exp_q.size(), 0);

    // Reset while the second coin of 40 is presented
    bus.coin_ready = 1'b0;
    exp_q.push_back(20);
    request(40);
    wait_coin();
    bus.coin_ready = 1'b1;
    tick();
    bus.coin_ready = 1'b0;
    wait_coin();
    chk("mid_remaining_pre", int'(remaining), 20);
    resetn = 1'b0;
    tick();
    chk("mid_coin_valid", int'(bus.coin_valid), 0);
    chk("mid_coin_val", int'(bus.coin_val), 0);
    chk("mid_remaining", int'(remaining), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_chg_ready", int'(bus.chg_ready), 1);
`ifdef CHG_INVENTORY_EN
    chk("mid_inv_20", int'(inv_20), 20);
`endif
    resetn = 1'b1;
    repeat (4) tick();
    chk("mid_no_coin_after", int'(bus.coin_valid), 0);
    chk("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
